// File: rtl/irq_pending_ctrl_if.sv
// Consumer-side valid/ready handshake carrying the offered interrupt index.
// The DUT drives through the master modport; the consumer uses the slave modport.
interface irq_pending_ctrl_if #(
    parameter int unsigned SIZE = 3
);
    logic [SIZE-1:0] code_out;
    logic            valid_out;
    logic            ready_in;

    modport master (
        output code_out,
        output valid_out,
        input  ready_in
    );

    modport slave (
        input  code_out,
        input  valid_out,
        output ready_in
    );
endinterface

// File: rtl/irq_pending_ctrl.sv
// irq_pending_ctrl: captures rising edges on 2**SIZE interrupt lines into a
// pending register, drives it active-low to an external leading-ones encoder,
// and offers the returned index over a valid/ready handshake. Events that hit
// an already-pending line are counted in a saturating drop counter.
// Optional build macro IRQ_MASK_EN adds a per-line mask input (1 = masked).
module irq_pending_ctrl #(
    parameter int unsigned SIZE   = 3,
    parameter int unsigned DROP_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2**SIZE-1:0]     irq_in,
`ifdef IRQ_MASK_EN
    input  logic [2**SIZE-1:0]     mask_in,
`endif
    output logic [2**SIZE-1:0]     pend_n_out,
    input  logic [SIZE-1:0]        code_in,
    output logic [DROP_W-1:0]      drop_cnt_out,
    irq_pending_ctrl_if.master     hs
);

    localparam int unsigned N     = 2**SIZE;
    localparam int unsigned CNT_W = SIZE + 1;
    localparam int unsigned SUM_W = ((DROP_W > CNT_W) ? DROP_W : CNT_W) + 1;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } state_t;

    state_t              state_q;
    logic                valid_q;
    logic [SIZE-1:0]     code_q;

    logic [N-1:0]        irq_q;
    logic [N-1:0]        pend_q;
    logic [N-1:0]        pend_d;
    logic [N-1:0]        line_en;
    logic [N-1:0]        rise;
    logic [N-1:0]        clr;
    logic [N-1:0]        drop_vec;
    logic [DROP_W-1:0]   drop_q;
    logic [DROP_W-1:0]   drop_d;
    logic [CNT_W-1:0]    drop_inc;
    logic [SUM_W-1:0]    drop_sum;
    logic                hs_fire;
    logic                any_pend;

`ifdef IRQ_MASK_EN
    assign line_en = ~mask_in;
`else
    assign line_en = '1;
`endif

    // Edge detect; masked lines still update irq_q so unmasking a held line is silent.
    assign rise     = irq_in & ~irq_q & line_en;
    assign hs_fire  = valid_q & hs.ready_in;
    // The encoder reports 0 for both "line 0" and "nothing", so decide from pending itself.
    assign any_pend = |pend_q;

    // Clear strobe for the line being accepted this cycle.
    always_comb begin
        clr = '0;
        for (int unsigned j = 0; j < N; j++) begin
            clr[j] = hs_fire && (code_q == SIZE'(j));
        end
    end

    // Pending next-state: a new rise wins over a same-cycle clear.
    assign pend_d   = (pend_q & ~clr) | rise;
    assign drop_vec = rise & pend_q & ~clr;

    // Saturating drop counter: add the number of rises that hit a still-pending line.
    always_comb begin
        drop_inc = '0;
        for (int unsigned j = 0; j < N; j++) begin
            drop_inc = drop_inc + CNT_W'(drop_vec[j]);
        end
        drop_sum = SUM_W'(drop_q) + SUM_W'(drop_inc);
        drop_d   = (drop_sum > SUM_W'(DROP_MAX)) ? DROP_MAX : DROP_W'(drop_sum);
    end

    // Bit-reverse and invert so the encoder's leading-ones count equals the line number.
    always_comb begin
        pend_n_out = '1;
        for (int unsigned j = 0; j < N; j++) begin
            pend_n_out[N-1-j] = ~pend_q[j];
        end
    end

    // Edge history, pending register and drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q  <= '0;
            pend_q <= '0;
            drop_q <= '0;
        end else begin
            irq_q  <= irq_in;
            pend_q <= pend_d;
            drop_q <= drop_d;
        end
    end

    // Offer FSM: capture the encoder result in IDLE, hold it in VALID until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            code_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_pend) begin
                        code_q  <= code_in;
                        valid_q <= 1'b1;
                        state_q <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (hs.ready_in) begin
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign hs.code_out   = code_q;
    assign hs.valid_out  = valid_q;
    assign drop_cnt_out  = drop_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Bench for irq_pending_ctrl: behavioural leading-ones encoder closes the loop,
// expected offered codes go through a queue checked on each handshake, and
// directed checks cover latency, priority, saturation, set-over-clear and reset.
module tb_irq_pending_ctrl;

    localparam int unsigned SIZE   = 3;
    localparam int unsigned DROP_W = 8;
    localparam int unsigned N      = 2**SIZE;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      irq_in;
    logic [N-1:0]      pend_n_out;
    logic [SIZE-1:0]   code_in;
    logic [DROP_W-1:0] drop_cnt_out;
`ifdef IRQ_MASK_EN
    logic [N-1:0]      mask_in;
`endif

    irq_pending_ctrl_if #(.SIZE(SIZE)) hs_if ();

    irq_pending_ctrl #(
        .SIZE   (SIZE),
        .DROP_W (DROP_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .irq_in       (irq_in),
`ifdef IRQ_MASK_EN
        .mask_in      (mask_in),
`endif
        .pend_n_out   (pend_n_out),
        .code_in      (code_in),
        .drop_cnt_out (drop_cnt_out),
        .hs           (hs_if)
    );

    always #5 clk = ~clk;

    int unsigned     n_cmp = 0;
    int unsigned     n_bad = 0;
    logic [SIZE-1:0] sb[$];
    logic [SIZE-1:0] sb_exp;
    int unsigned     lead;
    logic            stop;

    // Leading-ones encoder: count ones from the MSB down to the first zero.
    always_comb begin
        lead = 0;
        stop = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!stop && pend_n_out[i] === 1'b1) lead++;
            else stop = 1'b1;
        end
        code_in = SIZE'(lead);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input int unsigned n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Handshake monitor: inputs are stable mid-cycle, so a handshake seen here fires on the next edge.
    always @(negedge clk) begin
        if (rst === 1'b0 && hs_if.valid_out === 1'b1 && hs_if.ready_in === 1'b1) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                sb_exp = sb.pop_front();
                check("sb_code", 32'(hs_if.code_out), 32'(sb_exp));
            end
        end
    end

    initial begin
        rst            = 1'b1;
        irq_in         = '0;
        hs_if.ready_in = 1'b0;
`ifdef IRQ_MASK_EN
        mask_in        = '0;
`endif
        tick(2);
        check("rst_pend_n", 32'(pend_n_out), 32'hFF);
        check("rst_valid",  32'(hs_if.valid_out), 32'd0);
        rst = 1'b0;
        tick();
        check("rel_pend_n", 32'(pend_n_out), 32'hFF);
        check("rel_valid",  32'(hs_if.valid_out), 32'd0);
        check("rel_code",   32'(hs_if.code_out), 32'd0);
        check("rel_drop",   32'(drop_cnt_out), 32'd0);

        // Single pulse on line 5, consumer always ready.
        hs_if.ready_in = 1'b1;
        irq_in = 8'h20;
        sb.push_back(3'd5);
        tick();
        irq_in = '0;
        check("p5_pend_n_e1", 32'(pend_n_out), 32'hFB);
        check("p5_valid_e1",  32'(hs_if.valid_out), 32'd0);
        tick();
        check("p5_valid_e2",  32'(hs_if.valid_out), 32'd1);
        check("p5_code_e2",   32'(hs_if.code_out), 32'd5);
        tick();
        check("p5_valid_e3",  32'(hs_if.valid_out), 32'd0);
        check("p5_pend_n_e3", 32'(pend_n_out), 32'hFF);

        // Lines 6 and 2 together: 2 first, 6 after the bubble.
        irq_in = 8'h44;
        sb.push_back(3'd2);
        sb.push_back(3'd6);
        tick();
        irq_in = '0;
        tick();
        check("p26_valid_e2", 32'(hs_if.valid_out), 32'd1);
        check("p26_code_e2",  32'(hs_if.code_out), 32'd2);
        tick();
        check("p26_bubble",   32'(hs_if.valid_out), 32'd0);
        tick();
        check("p26_valid_e4", 32'(hs_if.valid_out), 32'd1);
        check("p26_code_e4",  32'(hs_if.code_out), 32'd6);
        tick();
        check("p26_valid_e5", 32'(hs_if.valid_out), 32'd0);
        check("p26_pend_n",   32'(pend_n_out), 32'hFF);

        // Line 4 re-raised on the accepting edge: set wins, re-offered after the bubble.
        hs_if.ready_in = 1'b0;
        irq_in = 8'h10;
        sb.push_back(3'd4);
        tick();
        irq_in = '0;
        tick();
        check("p4_valid", 32'(hs_if.valid_out), 32'd1);
        check("p4_code",  32'(hs_if.code_out), 32'd4);
        hs_if.ready_in = 1'b1;
        irq_in = 8'h10;
        sb.push_back(3'd4);
        tick();
        irq_in = '0;
        check("p4_keep_pend_n", 32'(pend_n_out), 32'hF7);
        check("p4_bubble",      32'(hs_if.valid_out), 32'd0);
        check("p4_drop_e3",     32'(drop_cnt_out), 32'd0);
        tick();
        check("p4_reoffer_valid", 32'(hs_if.valid_out), 32'd1);
        check("p4_reoffer_code",  32'(hs_if.code_out), 32'd4);
        tick();
        check("p4_done_valid",  32'(hs_if.valid_out), 32'd0);
        check("p4_done_pend_n", 32'(pend_n_out), 32'hFF);
        check("p4_drop_final",  32'(drop_cnt_out), 32'd0);

        // Line 3 stalled, 300 more pulses: counter saturates, offer held.
        hs_if.ready_in = 1'b0;
        irq_in = 8'h08;
        sb.push_back(3'd3);
        tick();
        irq_in = '0;
        tick();
        for (int k = 1; k <= 300; k++) begin
            irq_in = 8'h08;
            tick();
            irq_in = '0;
            tick();
            check("p3_hold_valid", 32'(hs_if.valid_out), 32'd1);
            check("p3_hold_code",  32'(hs_if.code_out), 32'd3);
            if (k == 100) check("p3_drop_100", 32'(drop_cnt_out), 32'd100);
            if (k == 255) check("p3_drop_255", 32'(drop_cnt_out), 32'd255);
        end
        check("p3_drop_sat", 32'(drop_cnt_out), 32'd255);
        hs_if.ready_in = 1'b1;
        tick();
        check("p3_acc_valid",  32'(hs_if.valid_out), 32'd0);
        check("p3_acc_pend_n", 32'(pend_n_out), 32'hFF);
        tick(2);
        check("p3_no_reoffer", 32'(hs_if.valid_out), 32'd0);

        // Reset while offering with lines 1 and 7 pending.
        hs_if.ready_in = 1'b0;
        irq_in = 8'h82;
        tick();
        irq_in = '0;
        tick();
        check("r_valid_pre", 32'(hs_if.valid_out), 32'd1);
        check("r_code_pre",  32'(hs_if.code_out), 32'd1);
        rst = 1'b1;
        #1;
        check("r_pend_n", 32'(pend_n_out), 32'hFF);
        check("r_valid",  32'(hs_if.valid_out), 32'd0);
        check("r_code",   32'(hs_if.code_out), 32'd0);
        check("r_drop",   32'(drop_cnt_out), 32'd0);
        tick(2);
        rst = 1'b0;
        hs_if.ready_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("r_post_valid", 32'(hs_if.valid_out), 32'd0);
        end
        check("r_post_pend_n", 32'(pend_n_out), 32'hFF);

        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
